// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and instruction memory (slave).
// Handshake: imem_req/imem_addr are held by the master until a cycle with imem_ready=1;
// in that cycle imem_rdata is the word at imem_addr. Dropping imem_req cancels any in-flight access.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the PC, obeys hazard stalls and EX redirects.
// Optional macro FETCH_STATS_EN adds saturating fetched/stall-cycle counters.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [3:0]             HALT_OPCODE = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_stall_i,
  input  logic                   ifid_stall_i,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  fetch_stage_if.master          imem,
  output logic                   d_valid_o,
  output logic [INSTR_WIDTH-1:0] d_instr_o,
  output logic [PC_WIDTH-1:0]    d_pc_plus1_o,
  output logic                   halted_o,
  output logic [1:0]             state_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched_o,
  output logic [31:0]            stat_stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   d_valid_q, d_valid_d;
  logic [INSTR_WIDTH-1:0] d_instr_q, d_instr_d;
  logic [PC_WIDTH-1:0]    d_pc_plus1_q, d_pc_plus1_d;

  // Stall inputs count as asserted only when they are a clean 1.
  logic pc_stall, ifid_stall, redirect;
  logic transfer, is_halt;
  logic [PC_WIDTH-1:0] pc_plus1;

  assign pc_stall   = (pc_stall_i === 1'b1);
  assign ifid_stall = (ifid_stall_i === 1'b1);
  assign redirect   = (redirect_valid_i === 1'b1);

  assign pc_plus1 = pc_q + PC_WIDTH'(1);
  assign is_halt  = (imem.imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
  assign transfer = (state_q == ST_FETCH) && imem.imem_ready && !pc_stall
                    && !ifid_stall && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      d_valid_q    <= 1'b0;
      d_instr_q    <= NOP_INSTR;
      d_pc_plus1_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      d_valid_q    <= d_valid_d;
      d_instr_q    <= d_instr_d;
      d_pc_plus1_q <= d_pc_plus1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    d_valid_d    = d_valid_q;
    d_instr_d    = d_instr_q;
    d_pc_plus1_d = d_pc_plus1_q;

    if (redirect) begin
      pc_d      = redirect_pc_i;
      d_valid_d = 1'b0;
      d_instr_d = NOP_INSTR;
      state_d   = ST_FLUSH;
    end else begin
      if (transfer) begin
        d_valid_d    = 1'b1;
        d_instr_d    = imem.imem_rdata;
        d_pc_plus1_d = pc_plus1;
        pc_d         = pc_plus1;
        if (is_halt) state_d = ST_HALTED;
      end else if (!ifid_stall) begin
        // Nothing new to hand over and decode is not holding: insert a bubble.
        d_valid_d = 1'b0;
        d_instr_d = NOP_INSTR;
      end
      if (state_q == ST_FLUSH) state_d = ST_FETCH;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign d_valid_o      = d_valid_q;
  assign d_instr_o      = d_instr_q;
  assign d_pc_plus1_o   = d_pc_plus1_q;
  assign halted_o       = (state_q == ST_HALTED);
  assign state_o        = state_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_stall_d   = stat_stall_q;
    if (transfer && (stat_fetched_q != 32'hFFFF_FFFF))
      stat_fetched_d = stat_fetched_q + 32'd1;
    if ((state_q == ST_FETCH) && pc_stall && (stat_stall_q != 32'hFFFF_FFFF))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched_o      = stat_fetched_q;
  assign stat_stall_cycles_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random ready/stall run.
// Fetched words are scoreboarded as {instr, pc_plus1} against a behavioural memory.
module tb_fetch_stage;
  localparam int PW = 16;
  localparam int IW = 16;

  logic          clk;
  logic          rst;
  logic          pc_stall;
  logic          ifid_stall;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          d_valid;
  logic [IW-1:0] d_instr;
  logic [PW-1:0] d_pc_plus1;
  logic          halted;
  logic [1:0]    state_dbg;
  logic          ready_en;
`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetched;
  logic [31:0]   stat_stall_cycles;
`endif

  fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .pc_stall_i       (pc_stall),
    .ifid_stall_i     (ifid_stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem             (bus),
    .d_valid_o        (d_valid),
    .d_instr_o        (d_instr),
    .d_pc_plus1_o     (d_pc_plus1),
    .halted_o         (halted),
    .state_o          (state_dbg)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched_o      (stat_fetched),
    .stat_stall_cycles_o (stat_stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  function automatic logic [IW-1:0] mem_read(input logic [PW-1:0] a);
    case (a)
      16'h0000: mem_read = 16'h1234;
      16'h0001: mem_read = 16'h2345;
      16'h0002: mem_read = 16'h3456;
      16'h0006: mem_read = 16'hA111;
      16'h0009: mem_read = 16'hF000;
      default:  mem_read = {4'h1, a[11:0]};
    endcase
  endfunction

  assign bus.imem_ready = ready_en;
  assign bus.imem_rdata = mem_read(bus.imem_addr);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic        ifid_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [PW-1:0] pc);
    logic [PW-1:0] nxt;
    nxt = pc + 16'd1;
    exp_q.push_back({mem_read(pc), nxt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) ifid_last <= ifid_stall;

  // A newly loaded IF/ID word is visible on the negedge after any edge where decode was not holding.
  always @(negedge clk) begin
    if (!rst && d_valid === 1'b1 && !ifid_last) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch", {d_instr, d_pc_plus1}, 32'h0);
      end else begin
        check("fetch_word", {d_instr, d_pc_plus1}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [PW-1:0] pc_m;

  initial begin
    rst = 1'b1; pc_stall = 1'b0; ifid_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; ready_en = 1'b1;
    #1;
    check("rst_req_pre", {31'b0, bus.imem_req}, 32'd0);
    step();
    check("rst_d_valid", {31'b0, d_valid}, 32'd0);
    check("rst_d_instr", {16'b0, d_instr}, 32'h0);
    check("rst_d_pc1", {16'b0, d_pc_plus1}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("run_req", {31'b0, bus.imem_req}, 32'd1);

    // Single-cycle memory streaming from address 0.
    for (int i = 0; i < 5; i++) begin
      check("seq_addr", {16'b0, bus.imem_addr}, i);
      push_exp(PW'(i));
      step();
    end

    // Memory not ready for three cycles at address 5.
    ready_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("wait_addr", {16'b0, bus.imem_addr}, 32'd5);
      check("wait_req", {31'b0, bus.imem_req}, 32'd1);
      step();
      check("wait_bubble", {31'b0, d_valid}, 32'd0);
    end
    ready_en = 1'b1;
    push_exp(16'd5);
    step();
    check("after_wait_addr", {16'b0, bus.imem_addr}, 32'd6);
    push_exp(16'd6);
    step();
    check("a111_loaded", {16'b0, d_instr}, 32'hA111);

    // Hazard stall of both PC and IF/ID.
    pc_stall = 1'b1; ifid_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_instr", {16'b0, d_instr}, 32'hA111);
      check("stall_valid", {31'b0, d_valid}, 32'd1);
      check("stall_addr", {16'b0, bus.imem_addr}, 32'd7);
    end
    pc_stall = 1'b0; ifid_stall = 1'b0;
    push_exp(16'd7); step();
    push_exp(16'd8); step();

    // Halt instruction at pc 9.
    push_exp(16'd9);
    step();
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_req", {31'b0, bus.imem_req}, 32'd0);
    check("halt_instr", {16'b0, d_instr}, 32'hF000);
    check("halt_valid", {31'b0, d_valid}, 32'd1);
    check("halt_pc", {16'b0, bus.imem_addr}, 32'd10);
    step();
    check("halted_bubble", {31'b0, d_valid}, 32'd0);
    check("halted_nop", {16'b0, d_instr}, 32'h0);
    check("halted_stay", {31'b0, halted}, 32'd1);

    // Redirect out of HALTED.
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect_valid = 1'b0;
    check("redir_halted", {31'b0, halted}, 32'd0);
    check("redir_flush_req", {31'b0, bus.imem_req}, 32'd0);
    check("redir_d_valid", {31'b0, d_valid}, 32'd0);
    step();
    check("redir_addr", {16'b0, bus.imem_addr}, 32'h20);
    check("redir_req", {31'b0, bus.imem_req}, 32'd1);
    push_exp(16'h0020);
    step();

    // Redirect while both stalls are asserted.
    pc_stall = 1'b1; ifid_stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    pc_stall = 1'b0; ifid_stall = 1'b0; redirect_valid = 1'b0;
    check("redir_stall_valid", {31'b0, d_valid}, 32'd0);
    check("redir_stall_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    check("redir_stall_addr", {16'b0, bus.imem_addr}, 32'h40);
    check("redir_stall_req2", {31'b0, bus.imem_req}, 32'd1);

    // pc_stall without ifid_stall bubbles decode.
    push_exp(16'h0040);
    step();
    pc_stall = 1'b1;
    step();
    check("pcstall_bubble", {31'b0, d_valid}, 32'd0);
    check("pcstall_addr", {16'b0, bus.imem_addr}, 32'h41);
    pc_stall = 1'b0;

    // PC wrap at 16'hFFFF.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_addr", {16'b0, bus.imem_addr}, 32'hFFFF);
    push_exp(16'hFFFF);
    step();
    check("wrap_pc1", {16'b0, d_pc_plus1}, 32'h0);
    check("wrap_next_addr", {16'b0, bus.imem_addr}, 32'h0);

    // Back-to-back redirects: second one during FLUSH wins.
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_pc = 16'h0200;
    step();
    redirect_valid = 1'b0;
    check("reflush_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    check("reflush_addr", {16'b0, bus.imem_addr}, 32'h200);

    // Random memory latency and hazard stalls.
    pc_m = 16'h0200;
    for (int c = 0; c < 200; c++) begin
      logic st;
      ready_en = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      pc_stall = st; ifid_stall = st;
      if (ready_en && !st) begin
        push_exp(pc_m);
        pc_m = pc_m + 16'd1;
      end
      step();
    end
    pc_stall = 1'b0; ifid_stall = 1'b0; ready_en = 1'b0;
    step();
    step();
    check("rand_addr", {16'b0, bus.imem_addr}, {16'b0, pc_m});
    check("queue_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a wait abandons everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_addr", {16'b0, bus.imem_addr}, 32'h0);
    check("mid_rst_valid", {31'b0, d_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
